// File: rtl/residu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : residu_pkg
// Description : Shared constants and state encoding for the residu LP
//               analysis (inverse) filter.
// Revision    : 1.0  initial release
// ============================================================================
package residu_pkg;

    // Subframe length and LP order defaults
    localparam int c_SUBFRAME_LEN = 40;
    localparam int c_LP_ORDER     = 10;

    // Post-accumulation scaling and rounding applied to every sample
    localparam logic [15:0] c_SHL_COUNT   = 16'd3;
    localparam logic [31:0] c_ROUND_CONST = 32'h0000_8000;

    // Width of the in-block index used to form scratch-memory addresses
    localparam int c_IDX_W = 6;

    // Controller state encoding
    typedef enum logic [3:0] {
        S_INIT  = 4'd0,
        S_N_CHK = 4'd1,
        S_LD_X0 = 4'd2,
        S_MULT  = 4'd3,
        S_J_CHK = 4'd4,
        S_LD_A  = 4'd5,
        S_MAC   = 4'd6,
        S_SHL1  = 4'd7,
        S_SHL2  = 4'd8,
        S_ROUND = 4'd9,
        S_INC   = 4'd10
    } state_t;

endpackage : residu_pkg
`default_nettype wire

// File: rtl/residu.sv
`default_nettype none
// ============================================================================
// Module      : residu
// Description : LP analysis filter. Computes one subframe of residual
//               y[n] = sum_{j=0..M} a[j]*x[n-j] using the external shared
//               L_mult / L_mac / L_shl / L_add units and a scratch memory
//               with one-cycle read latency. All arithmetic (including the
//               loop counter increments) goes through the shared units.
// Revision    : 1.0  initial release
// ============================================================================
module residu
    import residu_pkg::*;
#(
    parameter int L = c_SUBFRAME_LEN,
    parameter int M = c_LP_ORDER
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        done,
    input  logic [10:0] xAddr,
    input  logic [10:0] aAddr,
    input  logic [10:0] yAddr,
    input  logic [31:0] memIn,
    output logic [10:0] memWriteAddr,
    output logic        memWriteEn,
    output logic [31:0] memOut,
    output logic [15:0] L_multOutA,
    output logic [15:0] L_multOutB,
    input  logic [31:0] L_multIn,
    output logic [15:0] L_macOutA,
    output logic [15:0] L_macOutB,
    output logic [31:0] L_macOutC,
    input  logic [31:0] L_macIn,
    output logic [31:0] L_addOutA,
    output logic [31:0] L_addOutB,
    input  logic [31:0] L_addIn,
    output logic [31:0] L_shlOutVar1,
    output logic [15:0] L_shlNumShiftOut,
    output logic        L_shlReady,
    input  logic [31:0] L_shlIn,
    input  logic        L_shlDone
);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [31:0]         r_s;       // running accumulator
    logic [15:0]         r_x0;      // x[n] held for the initial L_mult
    logic [15:0]         r_a;       // a[j] held for the following L_mac
    logic [c_IDX_W-1:0]  r_n;       // sample index
    logic [3:0]          r_j;       // tap index

    state_t              w_stateNext;
    logic [31:0]         w_sNext;
    logic [15:0]         w_x0Next;
    logic [15:0]         w_aNext;
    logic [c_IDX_W-1:0]  w_nNext;
    logic [3:0]          w_jNext;

    // Index of x[n] and x[n-j] inside the x block: x[k] sits at M+k, so
    // these never go negative for n >= 0 and j <= M.
    logic [c_IDX_W-1:0]  w_idxXn;
    logic [c_IDX_W-1:0]  w_idxXnj;
    logic                w_nAtEnd;
    logic                w_jPastEnd;

    // Address low bits and the upper memory word are intentionally ignored
    logic                w_unused;

    assign w_idxXn    = c_IDX_W'(M) + r_n;
    assign w_idxXnj   = c_IDX_W'(M) + r_n - {2'b00, r_j};
    assign w_nAtEnd   = (r_n >= c_IDX_W'(L));
    assign w_jPastEnd = (r_j > 4'(M));
    assign w_unused   = ^{xAddr[5:0], aAddr[5:0], yAddr[5:0], memIn[31:16]};

    // State and datapath register update; reset returns straight to INIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_INIT;
            r_s     <= '0;
            r_x0    <= '0;
            r_a     <= '0;
            r_n     <= '0;
            r_j     <= '0;
        end else begin
            r_state <= w_stateNext;
            r_s     <= w_sNext;
            r_x0    <= w_x0Next;
            r_a     <= w_aNext;
            r_n     <= w_nNext;
            r_j     <= w_jNext;
        end
    end

    // Next-state, next register values and all outputs from current state
    always_comb begin
        w_stateNext      = r_state;
        w_sNext          = r_s;
        w_x0Next         = r_x0;
        w_aNext          = r_a;
        w_nNext          = r_n;
        w_jNext          = r_j;

        done             = 1'b0;
        memWriteAddr     = '0;
        memWriteEn       = 1'b0;
        memOut           = '0;
        L_multOutA       = '0;
        L_multOutB       = '0;
        L_macOutA        = '0;
        L_macOutB        = '0;
        L_macOutC        = '0;
        L_addOutA        = '0;
        L_addOutB        = '0;
        L_shlOutVar1     = '0;
        L_shlNumShiftOut = '0;
        L_shlReady       = 1'b0;

        case (r_state)
            S_INIT: begin
                w_nNext = '0;
                w_jNext = '0;
                if (start) begin
                    w_stateNext = S_N_CHK;
                end
            end

            S_N_CHK: begin
                if (w_nAtEnd) begin
                    done        = 1'b1;
                    w_stateNext = S_INIT;
                end else begin
                    memWriteAddr = {xAddr[10:6], w_idxXn};
                    w_stateNext  = S_LD_X0;
                end
            end

            S_LD_X0: begin
                w_x0Next     = memIn[15:0];
                memWriteAddr = {aAddr[10:6], 6'd0};
                w_stateNext  = S_MULT;
            end

            S_MULT: begin
                // memIn carries a[0] this cycle
                L_multOutA  = r_x0;
                L_multOutB  = memIn[15:0];
                w_sNext     = L_multIn;
                w_jNext     = 4'd1;
                w_stateNext = S_J_CHK;
            end

            S_J_CHK: begin
                if (w_jPastEnd) begin
                    w_stateNext = S_SHL1;
                end else begin
                    memWriteAddr = {aAddr[10:6], 2'b00, r_j};
                    w_stateNext  = S_LD_A;
                end
            end

            S_LD_A: begin
                w_aNext      = memIn[15:0];
                memWriteAddr = {xAddr[10:6], w_idxXnj};
                w_stateNext  = S_MAC;
            end

            S_MAC: begin
                // memIn carries x[n-j]; L_add is free here for j++
                L_macOutA   = r_a;
                L_macOutB   = memIn[15:0];
                L_macOutC   = r_s;
                w_sNext     = L_macIn;
                L_addOutA   = {28'd0, r_j};
                L_addOutB   = 32'd1;
                w_jNext     = L_addIn[3:0];
                w_stateNext = S_J_CHK;
            end

            S_SHL1: begin
                L_shlReady       = 1'b1;
                L_shlOutVar1     = r_s;
                L_shlNumShiftOut = c_SHL_COUNT;
                w_stateNext      = S_SHL2;
            end

            S_SHL2: begin
                // Operands held stable while the shared shifter finishes
                L_shlOutVar1     = r_s;
                L_shlNumShiftOut = c_SHL_COUNT;
                if (L_shlDone) begin
                    w_sNext     = L_shlIn;
                    w_stateNext = S_ROUND;
                end
            end

            S_ROUND: begin
                L_addOutA    = r_s;
                L_addOutB    = c_ROUND_CONST;
                memWriteAddr = {yAddr[10:6], r_n};
                memWriteEn   = 1'b1;
                memOut       = {{16{L_addIn[31]}}, L_addIn[31:16]};
                w_stateNext  = S_INC;
            end

            S_INC: begin
                L_addOutA   = {26'd0, r_n};
                L_addOutB   = 32'd1;
                w_nNext     = L_addIn[c_IDX_W-1:0];
                w_stateNext = S_N_CHK;
            end

            default: begin
                w_stateNext = S_INIT;
            end
        endcase
    end

endmodule : residu
`default_nettype wire

// File: tb/tb_residu.sv
`default_nettype none
// ============================================================================
// Module      : tb_residu
// Description : Directed self-checking bench for residu. Provides the
//               scratch memory and behavioural models of the shared
//               saturating arithmetic units, runs one subframe per test
//               and compares y[] and timing against hand-derived values.
// Revision    : 1.0  initial release
// ============================================================================
module tb_residu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        done;
    logic [10:0] xAddr, aAddr, yAddr;
    logic [31:0] memIn = '0;
    logic [10:0] memWriteAddr;
    logic        memWriteEn;
    logic [31:0] memOut;
    logic [15:0] L_multOutA, L_multOutB;
    logic [31:0] L_multIn;
    logic [15:0] L_macOutA, L_macOutB;
    logic [31:0] L_macOutC, L_macIn;
    logic [31:0] L_addOutA, L_addOutB, L_addIn;
    logic [31:0] L_shlOutVar1;
    logic [15:0] L_shlNumShiftOut;
    logic        L_shlReady;
    logic [31:0] L_shlIn;
    logic        L_shlDone;

    int checkCount = 0;
    int passCount  = 0;

    // Scratch memory, written only by the loader
    logic [31:0] mem [0:2047];
    // Captured y writes plus the run id that wrote each slot
    logic [31:0] yOut [0:63];
    int          yTag [0:63];
    int          runId = 0;
    int          wrCount = 0;
    int          badAddr = 0;
    int          badWrite = 0;
    int          shlDelay = 0;

    logic        shlBusy = 1'b0;
    int          shlCnt = 0;
    logic [31:0] shlRes = '0;

    residu dut (
        .clk(clk), .reset(reset), .start(start), .done(done),
        .xAddr(xAddr), .aAddr(aAddr), .yAddr(yAddr), .memIn(memIn),
        .memWriteAddr(memWriteAddr), .memWriteEn(memWriteEn), .memOut(memOut),
        .L_multOutA(L_multOutA), .L_multOutB(L_multOutB), .L_multIn(L_multIn),
        .L_macOutA(L_macOutA), .L_macOutB(L_macOutB), .L_macOutC(L_macOutC),
        .L_macIn(L_macIn), .L_addOutA(L_addOutA), .L_addOutB(L_addOutB),
        .L_addIn(L_addIn), .L_shlOutVar1(L_shlOutVar1),
        .L_shlNumShiftOut(L_shlNumShiftOut), .L_shlReady(L_shlReady),
        .L_shlIn(L_shlIn), .L_shlDone(L_shlDone)
    );

    always #5 clk = ~clk;

    // ---------------- shared-unit models (G.729 basic operators) -------
    function automatic logic [31:0] lAdd(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {a[31], a} + {b[31], b};
        if (s[32] != s[31]) return s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return s[31:0];
    endfunction

    function automatic logic [31:0] lMult(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] p;
        if (a == 16'h8000 && b == 16'h8000) return 32'h7FFF_FFFF;
        p = $signed(a) * $signed(b);
        return p <<< 1;
    endfunction

    function automatic logic [31:0] lShl(input logic [31:0] x, input logic [15:0] n);
        logic [31:0] v;
        v = x;
        for (int i = 0; i < 32; i++) begin
            if (i < int'(n)) begin
                if (v[31] != v[30]) return v[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                v = v << 1;
            end
        end
        return v;
    endfunction

    assign L_multIn  = lMult(L_multOutA, L_multOutB);
    assign L_macIn   = lAdd(L_macOutC, lMult(L_macOutA, L_macOutB));
    assign L_addIn   = lAdd(L_addOutA, L_addOutB);
    assign L_shlIn   = shlRes;
    assign L_shlDone = shlBusy && (shlCnt == shlDelay);

    // Shifter model: latch on ready, raise done after shlDelay extra cycles
    always @(posedge clk) begin
        if (reset) begin
            shlBusy <= 1'b0;
        end else if (L_shlReady) begin
            shlRes  <= lShl(L_shlOutVar1, L_shlNumShiftOut);
            shlCnt  <= 0;
            shlBusy <= 1'b1;
        end else if (shlBusy) begin
            if (L_shlDone) shlBusy <= 1'b0;
            else           shlCnt  <= shlCnt + 1;
        end
    end

    // Memory read with one-cycle latency, and write capture
    always @(posedge clk) begin
        memIn <= mem[memWriteAddr];
        if (memWriteEn) begin
            wrCount <= wrCount + 1;
            if (shlBusy) badWrite <= badWrite + 1;
            if (memWriteAddr[10:6] != yAddr[10:6]) begin
                badAddr <= badAddr + 1;
            end else begin
                yOut[memWriteAddr[5:0]] <= memOut;
                yTag[memWriteAddr[5:0]] <= runId;
            end
        end
    end

    // ---------------- checking ----------------------------------------
    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs === exp) passCount++;
        else $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic int outputsNonZero();
        return int'(done) + int'(memWriteEn) + int'(L_shlReady)
             + int'(memWriteAddr != 0) + int'(memOut != 0)
             + int'(L_multOutA != 0) + int'(L_multOutB != 0)
             + int'(L_macOutA != 0) + int'(L_macOutB != 0) + int'(L_macOutC != 0)
             + int'(L_addOutA != 0) + int'(L_addOutB != 0)
             + int'(L_shlOutVar1 != 0) + int'(L_shlNumShiftOut != 0);
    endfunction

    // Hand-derived residual for each data set
    function automatic logic [31:0] expY(input int test, input int n);
        logic [15:0] e;
        case (test)
            1:       e = 16'(100 * n);
            2:       e = (n == 0) ? 16'd50 : 16'(200 * n - 100);
            3:       e = 16'h7FFF;
            default: e = 16'h8000;
        endcase
        return {{16{e[15]}}, e};
    endfunction

    // Fill x history, x, and a for a test (upper memory bits are junk)
    task automatic loadTest(input int test);
        logic [15:0] xv, av;
        for (int i = 0; i < 2048; i++) mem[i] = 32'hDEAD_0000;
        for (int k = -10; k < 40; k++) begin
            case (test)
                1:       xv = (k < 0) ? 16'd0 : 16'(100 * k);
                2:       xv = (k == -1) ? 16'd50 : ((k < 0) ? 16'd0 : 16'(100 * k));
                3:       xv = 16'h7FFF;
                default: xv = 16'h8001;
            endcase
            mem[{xAddr[10:6], 6'(10 + k)}] = {16'hDEAD, xv};
        end
        for (int j = 0; j <= 10; j++) begin
            case (test)
                1:       av = (j == 0) ? 16'd4096 : 16'd0;
                2:       av = (j <= 1) ? 16'd4096 : 16'd0;
                default: av = 16'h7FFF;
            endcase
            mem[{aAddr[10:6], 6'(j)}] = {16'hBEEF, av};
        end
    endtask

    // Caller is at a negedge with the DUT in INIT. Returns the done cycle,
    // counting the INIT cycle that samples start as cycle 0.
    task automatic runSubframe(input bit midStart, output int doneCyc);
        int cyc;
        doneCyc = -1;
        start = 1'b1;
        @(posedge clk);
        cyc = 1;
        for (int guard = 0; guard < 4000; guard++) begin
            @(negedge clk);
            start = midStart && (cyc == 100 || cyc == 777);
            if (done) begin
                doneCyc = cyc;
                break;
            end
            @(posedge clk);
            cyc++;
        end
        start = 1'b0;
        @(negedge clk);
        checkVal("done_one_cycle", 32'(done), 32'd0);
    endtask

    task automatic runAndCheck(input string name, input int test, input int expDone, input bit midStart);
        int doneCyc, wr0, ba0, bw0, tagBad;
        runId++;
        wr0 = wrCount; ba0 = badAddr; bw0 = badWrite;
        runSubframe(midStart, doneCyc);
        checkVal({name, "_done_cycle"}, 32'(doneCyc), 32'(expDone));
        checkVal({name, "_writes"}, 32'(wrCount - wr0), 32'd40);
        checkVal({name, "_out_of_block"}, 32'(badAddr - ba0), 32'd0);
        checkVal({name, "_write_in_wait"}, 32'(badWrite - bw0), 32'd0);
        tagBad = 0;
        for (int n = 0; n < 40; n++) if (yTag[n] != runId) tagBad++;
        checkVal({name, "_unwritten"}, 32'(tagBad), 32'd0);
        for (int n = 0; n < 40; n++)
            checkVal($sformatf("%s_y%0d", name, n), yOut[n], expY(test, n));
    endtask

    initial begin
        int abortCyc;
        for (int n = 0; n < 64; n++) yTag[n] = 0;
        reset = 1'b1;
        start = 1'b0;
        xAddr = 11'h047;   // low bits set on purpose: must be ignored
        aAddr = 11'h080;
        yAddr = 11'h0DB;
        loadTest(1);
        repeat (2) @(posedge clk);
        #1;
        checkVal("reset_outputs", 32'(outputsNonZero()), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        runAndCheck("t1_identity", 1, 1521, 1'b0);

        loadTest(2);
        runAndCheck("t2_two_tap", 2, 1521, 1'b0);

        loadTest(3);
        runAndCheck("t3_pos_sat", 3, 1521, 1'b0);

        loadTest(4);
        runAndCheck("t4_neg_sat", 4, 1521, 1'b0);

        loadTest(1);
        shlDelay = 3;
        runAndCheck("t5_shl_wait", 1, 1641, 1'b0);
        shlDelay = 0;

        // Abort a run with an asynchronous reset mid-cycle around cycle 500
        start = 1'b1;
        @(posedge clk);
        abortCyc = 1;
        @(negedge clk);
        start = 1'b0;
        while (abortCyc < 500) begin
            @(posedge clk);
            abortCyc++;
        end
        #2;
        reset = 1'b1;
        #1;
        checkVal("async_reset_outputs", 32'(outputsNonZero()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        checkVal("held_reset_outputs", 32'(outputsNonZero()), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        runAndCheck("t6_after_reset", 1, 1521, 1'b1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule : tb_residu
`default_nettype wire

// File: doc/residu.md
# residu

Analysis (LP inverse) filter for the G.729 datapath: computes the residual r[n] = Σ_{j=0..M} a[j]·x[n−j] for one 40-sample subframe. It is the A(z) counterpart of the 1/A(z) synthesis filter. It shares the same scratch-memory port style and the external shared arithmetic units (L_mult, L_mac, L_shl, L_add). The encoder's LP-residual and weighted-speech stages call it, and so does the postfilter.

## Interface
Parameters:
- L, 40, subframe length
- M, 10, LP order

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- start  in  1  begin one subframe; sampled only in INIT
- done  out  1  one-cycle pulse at completion
- xAddr  in  11  base of x history block; 64-aligned, low 6 bits ignored
- aAddr  in  11  base of a[0..M]; 64-aligned
- yAddr  in  11  base of y[0..L−1]; 64-aligned
- memIn  in  32  read data; only [15:0] used
- memWriteAddr  out  11  read/write address
- memWriteEn  out  1  write strobe
- memOut  out  32  write data: y[15:0], sign-extended
- L_multOutA, L_multOutB  out  16  L_mult operands; L_multIn  in  32  result
- L_macOutA, L_macOutB  out  16  L_mac operands; L_macOutC  out  32  accumulator; L_macIn  in  32  result
- L_addOutA, L_addOutB  out  32  L_add operands; L_addIn  in  32  result
- L_shlOutVar1  out  32; L_shlNumShiftOut  out  16; L_shlReady  out  1; L_shlIn  in  32; L_shlDone  in  1

## Operation
- Memory layout:
  - x[k] for k = −M..L−1 is at {xAddr[10:6], M+k}.
  - a[j] is at {aAddr[10:6], j}.
  - y[n] is written to {yAddr[10:6], n}.
- The y block must not overlap the x block; an overlap gives undefined results.
- Memory read: an address driven in cycle t returns data on memIn in cycle t+1.
- Per sample n (6-bit counter, 0..L−1):
  - s = L_mult(x[n], a[0]).
  - For j = 1..M: s = L_mac(s, a[j], x[n−j]).
  - s = L_shl(s, 3).
  - y[n] = L_add(s, 0x00008000)[31:16].
- Counter increments use L_add, same as in the synthesis filter.
- All saturation is performed by the shared units. The block does no arithmetic of its own beyond index formation: 6-bit M+n−j, never negative.
- FSM states:
  - INIT: clear counters; start → N_CHK.
  - N_CHK: n ≥ L → pulse done, go to INIT. Otherwise drive the x[n] address → LD_X0.
  - LD_X0: latch x0; drive the a[0] address → MULT.
  - MULT: s ← L_multIn; j ← 1 → J_CHK.
  - J_CHK: j > M → SHL1. Otherwise drive the a[j] address → LD_A.
  - LD_A: latch a; drive the x[n−j] address → MAC.
  - MAC: s ← L_macIn; j++ → J_CHK.
  - SHL1: drive L_shlReady with Var1 = s and shift = 3 → SHL2.
  - SHL2: hold until L_shlDone; on done, s ← L_shlIn → ROUND.
  - ROUND: write y[n] → INC.
  - INC: n++ → N_CHK.
- All outputs are combinational from state and registers. Outside the states that use them, every output defaults to 0.
- start is ignored outside INIT.

## Timing
- Reset values: every output is 0. Async reset forces INIT immediately, mid-operation included. No partial write completes after reset. Registers s, x0, a, n and j clear to 0.
- Cycle count, with L_shlDone high in the first SHL2 cycle:
  - Each sample takes 38 cycles: 3 + 3·M + 1 + 4.
  - start is seen in INIT at cycle 0. N_CHK for sample k occurs at cycle 1 + 38k. done pulses at cycle 1521.
- Each extra L_shlDone wait cycle adds exactly 1 cycle per sample.
- memWriteEn is high only in ROUND: exactly L writes per run, none elsewhere.
- done is high for exactly one cycle and the block is back in INIT the next cycle. A start in that next cycle begins a new run.

## Structure
- L, M, the shift count (3), the rounding constant (0x00008000) and the state encodings (4-bit) go in the shared paramList include.
- No sub-module: the arithmetic is the external shared units, and address generation is trivial concatenation.

## Test plan
- a = {4096, 0×10}; x[−10..−1] = 0; x[k] = 100k → y[n] = 100n; done at cycle 1521.
- a = {4096, 4096, 0×9}; x[−1] = 50; x[k] = 100k → y[0] = 50, y[n] = 200n − 100 for n ≥ 1.
- Positive saturation: a[j] = 32767 all; x = 32767 all → y = 32767 all.
- Negative saturation: a[j] = 32767 all; x = −32767 all → y = −32768 all (memOut = 0xFFFF8000).
- L_shlDone delayed 3 cycles every sample → identical y; done at cycle 1641; no writes during waits.
- reset asserted at cycle 500 → all outputs 0 asynchronously and FSM in INIT. A new start then reproduces the first test exactly; start pulses mid-run are ignored; exactly 40 writes, all in yAddr's block.
